// File: rtl/serial_tx_day3.sv
// serial_tx_day3: framed parallel-to-serial transmitter.
// Frame = start bit (0), DATA_W data bits LSB first, stop bit (1); each bit
// held for BIT_CYCLES clocks. Line idles high. A new word may be accepted in
// the final stop cycle so consecutive frames run without an idle gap.
module serial_tx_day3 #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               bit_end;
    logic               accept;

    // Status decode and handshake qualification from current state.
    always_comb begin
        bit_end = (cyc_q == CYC_LAST);
        done_o  = (state_q == STOP) && bit_end;
        ready_o = (state_q == IDLE) || done_o;
        busy_o  = (state_q != IDLE);
        accept  = valid_i && ready_o;
    end

    assign tx_o = tx_q;

    // Next-state: bit timing, shifting, and line level; a handshake overrides.
    always_comb begin
        state_d = state_q;
        cyc_d   = bit_end ? '0 : cyc_q + CYC_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                tx_d  = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Taken from IDLE or the last stop cycle; the latter gives back-to-back frames.
        if (accept) begin
            state_d = START;
            shreg_d = data_i;
            cyc_d   = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
        end
    end

    // State register; async reset drops any frame and forces the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_day3.sv
// Bench for serial_tx_day3: two instances (BIT_CYCLES=4 and 1), frame-position
// reference model, per-cycle output checks and a per-frame scoreboard.
module tb_serial_tx_day3;

    localparam int DW  = 8;
    localparam int BC0 = 4;
    localparam int BC1 = 1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2] = '{1'b1, 1'b1};
    logic [7:0] data  [2] = '{8'h00, 8'h00};
    logic       valid [2] = '{1'b0, 1'b0};
    logic       ready [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       done  [2];

    serial_tx_day3 #(.DATA_W(DW), .BIT_CYCLES(BC0)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    serial_tx_day3 #(.DATA_W(DW), .BIT_CYCLES(BC1)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int unsigned bcv(input int i);
        return (i == 0) ? BC0 : BC1;
    endfunction

    // Expected line level k clocks into a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int unsigned k, input int unsigned bc);
        int unsigned b;
        b = k / bc;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        return 1'b1;
    endfunction

    // Reference model: pos = clock index within current frame (1..len), 0 when idle.
    int unsigned pos [2] = '{0, 0};
    logic [7:0]  cur [2] = '{8'h00, 8'h00};
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int unsigned len;
            len = (DW + 2) * bcv(i);
            if (!rst_n[i]) begin
                pos[i] = 0;
                if (i == 0) q0.delete(); else q1.delete();
            end else if (valid[i] && (pos[i] == 0 || pos[i] == len)) begin
                pos[i] = 1;
                cur[i] = data[i];
                if (i == 0) q0.push_back(data[i]); else q1.push_back(data[i]);
            end else if (pos[i] == len) begin
                pos[i] = 0;
            end else if (pos[i] != 0) begin
                pos[i] = pos[i] + 1;
            end
        end
    end

    // Monitor: per-cycle output checks, plus frame capture scored on done_o.
    logic        fbuf [2][64];
    int unsigned flen [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int unsigned bc, len, p, errs;
            logic [7:0]  w, got;
            logic        etx;
            bc  = bcv(i);
            len = (DW + 2) * bc;
            p   = pos[i];
            if (!rst_n[i]) begin
                check($sformatf("rst_tx%0d", i), tx[i], 1);
                check($sformatf("rst_ready%0d", i), ready[i], 1);
                check($sformatf("rst_busy%0d", i), busy[i], 0);
                check($sformatf("rst_done%0d", i), done[i], 0);
                flen[i] = 0;
            end else begin
                etx = (p == 0) ? 1'b1 : exp_bit(cur[i], p - 1, bc);
                check($sformatf("tx%0d", i), tx[i], etx);
                check($sformatf("ready%0d", i), ready[i], (p == 0 || p == len));
                check($sformatf("busy%0d", i), busy[i], (p != 0));
                check($sformatf("done%0d", i), done[i], (p == len));
                if (busy[i]) begin
                    if (flen[i] < 64) fbuf[i][flen[i]] = tx[i];
                    flen[i]++;
                end
                if (done[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        check($sformatf("frame_unexpected%0d", i), 1, 0);
                    end else begin
                        w = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("frame_len%0d", i), flen[i], len);
                        errs = 0;
                        got  = '0;
                        if (flen[i] == len) begin
                            for (int unsigned k = 0; k < len; k++)
                                if (fbuf[i][k] !== exp_bit(w, k, bc)) errs++;
                            for (int unsigned j = 0; j < DW; j++)
                                got[j] = fbuf[i][(j + 1) * bc + bc / 2];
                        end
                        check($sformatf("frame_bits%0d", i), errs, 0);
                        check($sformatf("frame_word%0d", i), got, w);
                    end
                    flen[i] = 0;
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        data[i]  = d;
        valid[i] = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            if (ready[i]) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) check("handshake_timeout", 0, 1);
    endtask

    task automatic drop(input int i);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            idle = !busy[i];
        end
        if (!idle) check("idle_timeout", 0, 1);
    endtask

    initial begin
        // Reset with valid asserted: must stay idle.
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        valid[0] = 1'b1;
        valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        send(0, 8'hA5); drop(0); wait_idle(0);

        send(0, 8'h00); send(0, 8'hFF); drop(0); wait_idle(0);

        send(0, 8'h3C); drop(0);
        repeat (8) @(negedge clk);
        data[0]  = 8'hC3;
        valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(negedge clk);

        // Async reset in clock 15 of a frame.
        send(0, 8'hE7); drop(0);
        repeat (14) @(posedge clk);
        #3 rst_n[0] = 1'b0;
        #1;
        check("abort_tx", tx[0], 1);
        check("abort_done", done[0], 0);
        check("abort_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        send(0, 8'h81); drop(0); wait_idle(0);

        send(1, 8'h5A); drop(1); wait_idle(1);

        // Randomised traffic on both instances, mixing gaps and back-to-back.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 20; k++) begin
                send(i, 8'($urandom));
                if ($urandom_range(0, 2) != 0) begin
                    drop(i);
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                end
            end
            drop(i);
            wait_idle(i);
        end

        repeat (3) @(negedge clk);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
